// File: rtl/video_pkg.sv
// Shared raster constants for the 640x480 video timing block: default
// timing, derived totals, sync polarity encodings and the 4:4:4 colour type.
package video_pkg;

   localparam int CNT_W = 10;

   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;
   localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   // Width of one colour bar in the built-in test pattern.
   localparam int BAR_W_PX = 80;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Colour for bar index i: each index bit drives one full colour channel.
   function automatic rgb444_t bar_colour(input logic [2:0] i);
      rgb444_t c;
      c.r = {4{i[2]}};
      c.g = {4{i[1]}};
      c.b = {4{i[0]}};
      return c;
   endfunction

endpackage

// File: rtl/video_delay.sv
// Reset-clearing shift register used to align the raster flags with the
// pixel colour returned by the fetch logic. Reset empties every tap to zero.
module video_delay #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             dot_clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] taps [DEPTH];

   // Shift one tap per dot clock; reset flushes all taps to the inactive state.
   always_ff @(posedge dot_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      end else begin
         taps[0] <= din;
         for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      end
   end

   assign dout = taps[DEPTH-1];

endmodule

// File: rtl/video_timing.sv
// Raster timing and pixel output stage. Counts dots and lines, issues pixel
// coordinate requests, delays the raster flags by LATENCY to meet the
// returned colour, and registers RGB/syncs on a single dot_clk edge.
// Optional feature macro: VIDEO_TEST_PATTERN_EN (8 vertical colour bars
// selected by test_mode; without it test_mode is ignored).
module video_timing
   import video_pkg::*;
#(
   parameter int H_VIS     = VGA_H_VIS,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VIS     = VGA_V_VIS,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter bit HSYNC_POL = SYNC_ACTIVE_LOW,
   parameter bit VSYNC_POL = SYNC_ACTIVE_LOW,
   parameter int LATENCY   = 2
) (
   input  logic             dot_clk,
   input  logic             reset_n,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic             pix_req,
   input  logic [11:0]      pix_rgb,
   input  logic             test_mode,
   output logic [3:0]       r,
   output logic [3:0]       g,
   output logic [3:0]       b,
   output logic             hsync,
   output logic             vsync,
   output logic             frame_start
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   // Raster totals must fit the 10-bit counters and the latency must be legal.
   generate
      if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
         $error("video_timing: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
      end
      if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
         $error("video_timing: LATENCY must be within 1..4");
      end
   endgenerate

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VIS);
   localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VIS);
   localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_VIS + H_FP);
   localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_VIS + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_VIS + V_FP);
   localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_VIS + V_FP + V_SYNC);

   // ---- stage 0: raster counters and request/flag decode ----
   logic [CNT_W-1:0] hc_p0, vc_p0;
   logic             active_p0, hs_raw_p0, vs_raw_p0, first_p0;

   // Free-running dot/line counters; the line counter steps on each dot wrap.
   always_ff @(posedge dot_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_p0 <= '0;
         vc_p0 <= '0;
      end else if (hc_p0 == H_LAST) begin
         hc_p0 <= '0;
         vc_p0 <= (vc_p0 == V_LAST) ? '0 : vc_p0 + CNT_W'(1);
      end else begin
         hc_p0 <= hc_p0 + CNT_W'(1);
      end
   end

   assign active_p0 = (hc_p0 < H_VIS_C) && (vc_p0 < V_VIS_C);
   assign hs_raw_p0 = (hc_p0 >= HS_START_C) && (hc_p0 < HS_END_C);
   assign vs_raw_p0 = (vc_p0 >= VS_START_C) && (vc_p0 < VS_END_C);
   assign first_p0  = (hc_p0 == '0) && (vc_p0 == '0);

   // The request is held low while reset is applied even though the counters sit at (0,0).
   assign pix_req = reset_n & active_p0;
   assign pix_x   = pix_req ? hc_p0 : '0;
   assign pix_y   = pix_req ? vc_p0 : '0;

`ifdef VIDEO_TEST_PATTERN_EN
   localparam int FLAG_W = 8;

   // Bar index is hc/80 evaluated as a threshold chain rather than a divider.
   function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] x);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (x >= CNT_W'(i * BAR_W_PX)) idx = 3'(i);
      end
      return idx;
   endfunction

   logic [2:0] bar_p0;
   assign bar_p0 = bar_index(hc_p0);
`else
   localparam int FLAG_W = 4;
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
`endif

   logic [FLAG_W-1:0] flags_p0, flags_p1;

`ifdef VIDEO_TEST_PATTERN_EN
   assign flags_p0 = {bar_p0, test_mode, first_p0, vs_raw_p0, hs_raw_p0, active_p0};
`else
   assign flags_p0 = {first_p0, vs_raw_p0, hs_raw_p0, active_p0};
`endif

   // ---- stage 1: flags delayed LATENCY cycles to meet the returned colour ----
   video_delay #(
      .WIDTH (FLAG_W),
      .DEPTH (LATENCY)
   ) u_flag_delay (
      .dot_clk (dot_clk),
      .reset_n (reset_n),
      .din     (flags_p0),
      .dout    (flags_p1)
   );

   logic active_p1, hs_p1, vs_p1, first_p1;
   assign active_p1 = flags_p1[0];
   assign hs_p1     = flags_p1[1];
   assign vs_p1     = flags_p1[2];
   assign first_p1  = flags_p1[3];

`ifdef VIDEO_TEST_PATTERN_EN
   logic       tm_p1;
   logic [2:0] bar_p1;
   assign tm_p1  = flags_p1[4];
   assign bar_p1 = flags_p1[7:5];
`endif

   // ---- stage 2: output register driving the pins ----
   rgb444_t rgb_p2;

   // Register colour and syncs together; blanking forces the colour to black.
   always_ff @(posedge dot_clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_p2      <= '0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         frame_start <= 1'b0;
      end else begin
         if (!active_p1) begin
            rgb_p2 <= '0;
         end else begin
`ifdef VIDEO_TEST_PATTERN_EN
            rgb_p2 <= tm_p1 ? bar_colour(bar_p1) : rgb444_t'(pix_rgb);
`else
            rgb_p2 <= rgb444_t'(pix_rgb);
`endif
         end
         hsync       <= hs_p1 ^ ~HSYNC_POL;
         vsync       <= vs_p1 ^ ~VSYNC_POL;
         frame_start <= first_p1;
      end
   end

   assign r = rgb_p2.r;
   assign g = rgb_p2.g;
   assign b = rgb_p2.b;

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench for video_timing. Horizontal timing is the default
// 800-dot line; the vertical raster is shortened (23 lines) so several
// frames fit in a short run. Each cycle the expected pin state for the
// current stage-0 position is queued and popped LATENCY+1 edges later.
module tb_video_timing;

   localparam int L  = 2;
   localparam int HV = 640, HF = 16, HS = 96, HB = 48;
   localparam int HT = HV + HF + HS + HB;
   localparam int VV = 16, VF = 2, VS = 2, VB = 3;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        dot_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] pix_rgb = 12'h000;
   logic        test_mode = 1'b0;
   logic [9:0]  pix_x, pix_y;
   logic        pix_req;
   logic [3:0]  r, g, b;
   logic        hsync, vsync, frame_start;

   video_timing #(
      .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .LATENCY (L)
   ) dut (
      .dot_clk     (dot_clk),
      .reset_n     (reset_n),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_req     (pix_req),
      .pix_rgb     (pix_rgb),
      .test_mode   (test_mode),
      .r           (r),
      .g           (g),
      .b           (b),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start)
   );

   always #5 dot_clk = ~dot_clk;

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        fs;
   } out_t;

   typedef struct {
      out_t o;
      int   x;
      int   y;
   } sb_t;

   typedef struct packed {
      logic       req;
      logic [9:0] x;
      logic [9:0] y;
   } req_t;

   sb_t  sbq[$];
   req_t hist[$];

   int checks = 0;
   int errors = 0;
   int mx, my, mode, cyc;
   // sync/frame monitor state
   logic prev_hs, prev_vs;
   bit   hfall_seen, vfall_seen, fs_seen;
   int   last_hfall, last_fs, hlow, vlow;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic out_t model_out(input int x, input int y, input int md, input bit tm);
      out_t o;
      logic [2:0] bi;
      bit act;
      act  = (x < HV) && (y < VV);
      o.hs = (x >= HV + HF && x < HV + HF + HS) ? 1'b0 : 1'b1;
      o.vs = (y >= VV + VF && y < VV + VF + VS) ? 1'b0 : 1'b1;
      o.fs = (x == 0 && y == 0);
      bi   = 3'(x / 80);
      if (!act) o.rgb = 12'h000;
      else if (md == 1) o.rgb = 12'hFFF;
      else o.rgb = {4'(x), 4'(y), 4'hA};
`ifdef VIDEO_TEST_PATTERN_EN
      if (act && tm) o.rgb = {{4{bi[2]}}, {4{bi[1]}}, {4{bi[0]}}};
`else
      if (tm && bi == 3'd7 && !act) o.rgb = 12'h000;
`endif
      return o;
   endfunction

   task automatic check_reset_pins(input string tag);
      check({tag, "_rgb"}, {20'h0, r, g, b}, 32'h0);
      check({tag, "_sync"}, {29'h0, hsync, vsync, frame_start}, 32'h6);
      check({tag, "_req"}, {11'h0, pix_req, pix_x, pix_y}, 32'h0);
   endtask

   task automatic release_reset();
      sb_t e;
      @(posedge dot_clk);
      #2;
      reset_n = 1'b1;
      mx = 0; my = 0; cyc = 0;
      sbq.delete();
      hist.delete();
      e.o = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
      e.x = -1; e.y = -1;
      for (int i = 0; i < L; i++) sbq.push_back(e);
      prev_hs = 1'b1; prev_vs = 1'b1;
      hfall_seen = 0; vfall_seen = 0; fs_seen = 0;
      hlow = 0; vlow = 0; last_hfall = 0; last_fs = 0;
   endtask

   task automatic step();
      req_t cur, old;
      sb_t  e;
      out_t got;
      @(negedge dot_clk);
      cur.req = (mx < HV) && (my < VV);
      cur.x   = cur.req ? 10'(mx) : 10'd0;
      cur.y   = cur.req ? 10'(my) : 10'd0;
      check("pix_request", {11'h0, pix_req, pix_x, pix_y}, {11'h0, cur});
      // fetch model: colour for a request returns exactly L cycles later
      hist.push_back({pix_req, pix_x, pix_y});
      if (hist.size() > L) begin
         old = hist.pop_front();
         pix_rgb = (mode == 1) ? 12'hFFF : {old.x[3:0], old.y[3:0], 4'hA};
      end else begin
         pix_rgb = (mode == 1) ? 12'hFFF : 12'h000;
      end
      e.o = model_out(mx, my, mode, test_mode);
      e.x = mx; e.y = my;
      sbq.push_back(e);
      mx++;
      if (mx == HT) begin
         mx = 0;
         my = (my == VT - 1) ? 0 : my + 1;
      end

      @(posedge dot_clk);
      #1;
      cyc++;
      if (sbq.size() == 0) begin
         check("sb_underflow", 32'd0, 32'd1);
         return;
      end
      e   = sbq.pop_front();
      got = {r, g, b, hsync, vsync, frame_start};
      check("pins", {17'h0, got}, {17'h0, e.o});

      if (mode == 0 && !test_mode && e.x == 5 && e.y == 7)
         check("pixel_5_7", {20'h0, r, g, b}, 32'h57A);
      if (mode == 1 && e.x >= 0 && (e.x >= HV || e.y >= VV))
         check("blank_fff", {20'h0, r, g, b}, 32'h0);
      if (mode == 0 && test_mode && e.y == 0 && e.x == 85) begin
`ifdef VIDEO_TEST_PATTERN_EN
         check("bar_col85", {20'h0, r, g, b}, 32'h00F);
`else
         check("bar_col85", {20'h0, r, g, b}, 32'h50A);
`endif
      end
      if (mode == 0 && test_mode && e.y == 0 && e.x == 639) begin
`ifdef VIDEO_TEST_PATTERN_EN
         check("bar_col639", {20'h0, r, g, b}, 32'hFFF);
`else
         check("bar_col639", {20'h0, r, g, b}, 32'hF0A);
`endif
      end

      // hsync edge timing
      if (!prev_hs && hsync && hfall_seen) check("hsync_width", hlow, HS);
      if (prev_hs && !hsync) begin
         if (!hfall_seen) check("hsync_first", cyc, HV + HF + L + 1);
         else check("hsync_period", cyc - last_hfall, HT);
         hfall_seen = 1;
         last_hfall = cyc;
      end
      hlow = hsync ? 0 : hlow + 1;

      // vsync edge timing
      if (!prev_vs && vsync && vfall_seen) check("vsync_width", vlow, VS * HT);
      if (prev_vs && !vsync && !vfall_seen) begin
         check("vsync_first", cyc, (VV + VF) * HT + L + 1);
         vfall_seen = 1;
      end
      vlow = vsync ? 0 : vlow + 1;

      // frame_start timing
      if (frame_start) begin
         if (!fs_seen) check("frame_first", cyc, L + 1);
         else check("frame_period", cyc - last_fs, FRAME);
         fs_seen = 1;
         last_fs = cyc;
      end

      prev_hs = hsync;
      prev_vs = vsync;
   endtask

   initial begin
      int guard;
      mode = 0; cyc = 0;
      reset_n = 1'b0;
      repeat (3) @(posedge dot_clk);
      #1;
      check_reset_pins("por");

      // Phase 1: addressed pixel pattern, full frame plus one line
      release_reset();
      for (int i = 0; i < FRAME + 900; i++) step();

      // Run on to (300,10) and assert reset asynchronously mid-line
      guard = 0;
      while (!(mx == 300 && my == 10) && guard < FRAME) begin
         step();
         guard++;
      end
      check("reach_300_10", {mx[15:0], my[15:0]}, {16'd300, 16'd10});
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_pins("async_rst");
      repeat (3) @(posedge dot_clk);
      #1;
      check_reset_pins("rst_hold");

      // Phase 2: constant white source, blanking must stay black
      mode = 1;
      release_reset();
      for (int i = 0; i < FRAME + 900; i++) step();

      // Phase 3: test_mode asserted
      @(posedge dot_clk);
      #2;
      reset_n = 1'b0;
      mode = 0;
      test_mode = 1'b1;
      repeat (3) @(posedge dot_clk);
      release_reset();
      for (int i = 0; i < 2 * HT; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
